// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data-SRAM responder: FSM encoding and the
// default data-memory base address used by the fetch/data memory map.
package data_sram_resp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1c000000;

endpackage

// File: rtl/data_sram_resp_if.sv
// Request/response bus between the decode/execute path (master) and the
// data-SRAM responder (slave).
interface data_sram_resp_if;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_is_write;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_is_write, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_is_write, rsp_err, busy
  );

endinterface

// File: rtl/data_sram_bank.sv
// Byte-enabled single-port 32-bit array with a registered read; drop-in
// point for a vendor BRAM macro.
module data_sram_bank #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  // Read register only loads on a read access, so it holds across stalls.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == 4'h0) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: one outstanding request, one response beat per
// request after LATENCY cycles; writes commit at accept.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          LATENCY    = 1
) (
  input logic             clk,
  input logic             resetn,
  data_sram_resp_if.slave bus
);

  if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
    $error("data_sram_resp: LATENCY must be within 1..7");
  end

  localparam logic [32:0] SPAN     = 33'(4) << ADDR_WIDTH;
  localparam logic [2:0]  CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  state_t                state;
  logic [2:0]            cnt;
  logic                  is_write_p1;
  logic                  err_p1;
  logic                  rd_sel_p1;
  logic [31:0]           offset;
  logic                  in_range;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           bank_rdata;

  // Unsigned offset: addresses below BASE_ADDR wrap high and fall out of range.
  assign offset   = bus.req_addr - BASE_ADDR;
  assign in_range = ({1'b0, offset} < SPAN);
  assign idx      = offset[ADDR_WIDTH+1:2];

  assign bus.req_ready = (state == ST_IDLE) | ((state == ST_RESP) & bus.rsp_ready);
  assign accept        = bus.req_valid & bus.req_ready;

  data_sram_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
    .clk   (clk),
    .en    (accept & in_range),
    .we    (bus.req_we),
    .addr  (idx),
    .wdata (bus.req_wdata),
    .rdata (bank_rdata)
  );

  // ---- accept edge -> response stage (p1) ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      cnt         <= 3'd0;
      is_write_p1 <= 1'b0;
      err_p1      <= 1'b0;
      rd_sel_p1   <= 1'b0;
    end else if (accept) begin
      state       <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
      cnt         <= CNT_INIT;
      is_write_p1 <= (bus.req_we != 4'h0);
      err_p1      <= ~in_range;
      rd_sel_p1   <= in_range & (bus.req_we == 4'h0);
    end else begin
      case (state)
        ST_IDLE: ;
        ST_WAIT: begin
          if (cnt == 3'd0) state <= ST_RESP;
          else             cnt   <= cnt - 3'd1;
        end
        ST_RESP: if (bus.rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid    = (state == ST_RESP);
  assign bus.busy         = (state != ST_IDLE);
  assign bus.rsp_rdata    = rd_sel_p1 ? bank_rdata : 32'h0;
  assign bus.rsp_is_write = is_write_p1;
  assign bus.rsp_err      = err_p1;

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
Responder end of the data-SRAM request interface that the decode/execute path drives (enable, byte write-enables, address, write data). It holds a word-addressed data memory, accepts one request at a time and returns exactly one response beat per request after a fixed latency. It replaces the ideal 0-wait memory in simulation and FPGA builds, and exercises the pipeline's stall path.

Parameters:
ADDR_WIDTH, 10, word-index width; memory depth is 2**ADDR_WIDTH words of 32 bits
BASE_ADDR, 32'h1c000000, byte address of word 0
LATENCY, 1, cycles from accept to response valid; legal range 1..7

Ports:
clk  input  1  clock
resetn  input  1  asynchronous, active-low reset
req_valid  input  1  request present (data_sram_en or we != 0)
req_ready  output  1  request accepted this cycle when req_valid & req_ready
req_we  input  4  byte write enables; 4'h0 = read
req_addr  input  32  byte address; bits [1:0] ignored
req_wdata  input  32  store data, byte i on bits [8i+7:8i]
rsp_valid  output  1  response beat present
rsp_ready  input  1  consumer takes beat when rsp_valid & rsp_ready
rsp_rdata  output  32  read data; 0 for writes and errors
rsp_is_write  output  1  beat belongs to a write
rsp_err  output  1  address outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_WIDTH)
busy  output  1  a request is outstanding (state != IDLE); feeds the pipeline stall

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low. Reset asserts immediately, with no clock edge needed. Release is synchronous to clk.
- Reset values: state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_is_write=0, rsp_err=0. The memory array is not reset.
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1.
  - WAIT: cnt counts down. req_ready=0.
  - RESP: rsp_valid=1. req_ready=rsp_ready, which allows back-to-back requests.
- Accept at edge T (req_valid & req_ready):
  - Compute the index: idx = (req_addr - BASE_ADDR) >> 2.
  - The address is in range when (req_addr - BASE_ADDR), unsigned, is less than 4*2**ADDR_WIDTH.
  - Write and in range: each byte lane i with req_we[i]=1 is written at edge T. Other lanes are unchanged.
  - Read and in range: mem[idx] is captured into the response register at edge T.
  - Out of range: no memory change, rdata register=0, err register=1.
  - The is_write register is set to (req_we != 0).
- Latency:
  - LATENCY=1: next state is RESP. rsp_valid is high in cycle T+1.
  - LATENCY>1: next state is WAIT with cnt=LATENCY-2. WAIT decrements cnt each cycle. WAIT moves to RESP when cnt==0. rsp_valid is first high in cycle T+LATENCY.
- RESP:
  - Response fields stay stable while rsp_valid & !rsp_ready.
  - On rsp_ready with no new request, next state is IDLE and rsp_valid drops at the next edge.
  - On rsp_ready with a new request accepted in the same cycle, the new request is processed exactly as from IDLE. The next beat follows LATENCY cycles later.
- Ordering: a read following a write to the same word always sees the written bytes, because writes commit at accept and only one request is outstanding.
- busy equals (state != IDLE) and is combinational from the state register.
- Reset mid-operation: a pending response is dropped with no beat produced. A write already accepted stays committed.
- LATENCY outside 1..7 is a configuration error, flagged by an elaboration-time check.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - the default base-address constant 32'h1c000000, also used by the fetch/data memory map.
- Natural sub-module: data_sram_bank. It is the byte-enabled single-port 32-bit array with a synchronous registered read, so it can be swapped for a vendor BRAM macro. The FSM, counter and response registers stay in data_sram_resp.

Test Plan:
- After reset, LATENCY=1: write 32'hdeadbeef to 32'h1c000010 with we=4'hf, then read the same address. Required: write beat at T+1 with rsp_is_write=1 and rsp_rdata=0; read beat with rsp_rdata=32'hdeadbeef; req_ready high in each RESP cycle where rsp_ready=1.
- Byte lanes: preload 32'h11223344, then write 32'haabbccdd with we=4'b0101, then read. Required: rsp_rdata=32'h11bb33dd.
- LATENCY=3, read issued at cycle 5. Required: busy high in cycles 6-8; rsp_valid first high in cycle 8; req_ready low in cycles 6-7.
- Backpressure: hold rsp_ready=0 for 4 cycles in RESP. Required: rsp_valid and rsp_rdata stay stable, req_ready=0, and a held req_valid is not accepted until the cycle rsp_ready rises.
- Out of range: read 32'h1bfffffc, then write to BASE_ADDR + 4*2**ADDR_WIDTH. Required: both beats have rsp_err=1 and rsp_rdata=0; a subsequent read of word 0 is unchanged.
- Async reset: drop resetn between clock edges while in WAIT. Required: rsp_valid=0 and busy=0 immediately with no clock edge; no beat after release; an earlier accepted write still reads back correctly.
